nios_mul_pipe: RTL and testbench

- Parametrised, handshaked multiplier pipeline for the Nios II custom cores.
- Successor to the fixed three-partial-product multiplier cell. Adds:
  - full high-word results, selectable signed/unsigned per operand (mul, mulxss, mulxsu, mulxuu);
  - valid/ready backpressure, synchronous flush, and a tag sideband.
- Sits between the E stage operand muxes and the W-stage writeback arbiter of each core.

---
 rtl/nios_mul_pkg.sv | 21 ++
 rtl/nios_mul_pipe_if.sv | 31 +++
 rtl/nios_mul_pp.sv | 14 +
 rtl/nios_mul_pipe.sv | 103 ++++++++++
 tb/tb_nios_mul_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_mul_pkg.sv
// Shared types and helpers for the Nios II multiplier pipeline.
// op_e         : operation select (low word, or high word with signed/unsigned operand mix)
// is_signed_a/b: whether an operand is sign-extended for a given op
package nios_mul_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'b00,  // low word, signedness irrelevant
      OP_MULXSS = 2'b01,  // high word, signed x signed
      OP_MULXSU = 2'b10,  // high word, signed x unsigned
      OP_MULXUU = 2'b11   // high word, unsigned x unsigned
   } op_e;

   function automatic logic is_signed_a(op_e op);
      return (op == OP_MULXSS) || (op == OP_MULXSU);
   endfunction

   function automatic logic is_signed_b(op_e op);
      return (op == OP_MULXSS);
   endfunction

endpackage

// File: rtl/nios_mul_pipe_if.sv
// Handshake bundle for nios_mul_pipe.
// master: operand producer / result consumer (drives in_*, flush, out_ready)
// slave : the multiplier pipeline (drives in_ready, out_valid, out_result, out_tag)
interface nios_mul_pipe_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5
) ();

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );

endinterface

// File: rtl/nios_mul_pp.sv
// Combinational signed slice multiplier, W x W -> 2W bits.
// a_i, b_i : signed slice operands (unsigned slices arrive zero-extended)
// p_o      : signed product
module nios_mul_pp #(
   parameter int unsigned W = 17
) (
   input  logic signed [W-1:0]   a_i,
   input  logic signed [W-1:0]   b_i,
   output logic signed [2*W-1:0] p_o
);

   assign p_o = a_i * b_i;

endmodule

// File: rtl/nios_mul_pipe.sv
// Two-stage handshaked multiplier: S1 registers four slice partial products, S2 registers the
// selected word of their sum. Global stall when the output is held; flush kills all in-flight work.
// clk, reset_n : clock and asynchronous active-low reset
// bus (slave)  : flush, in_valid/in_ready/in_op/in_a/in_b/in_tag, out_valid/out_ready/out_result/out_tag
module nios_mul_pipe
   import nios_mul_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5
) (
   input logic            clk,
   input logic            reset_n,
   nios_mul_pipe_if.slave bus
);

   localparam int unsigned H   = DATA_W / 2;
   localparam int unsigned PPW = 2 * H + 2;
   localparam int unsigned PW  = 2 * DATA_W;

   op_e                   in_op;
   logic [DATA_W:0]       a_ext, b_ext;
   logic signed [H:0]     a_lo, a_hi, b_lo, b_hi;
   logic signed [PPW-1:0] ll_p, lh_p, hl_p, hh_p;
   logic                  adv;

   logic                  s1_valid_q, s2_valid_q;
   op_e                   op_q;
   logic [TAG_W-1:0]      tag1_q, tag2_q;
   logic signed [PPW-1:0] ll_q, lh_q, hl_q, hh_q;
   logic [PW-1:0]         prod;
   logic [DATA_W-1:0]     result_d, result_q;

   function automatic logic [PW-1:0] sext(logic signed [PPW-1:0] x);
      return {{(PW - PPW){x[PPW-1]}}, x};
   endfunction

   assign in_op = op_e'(bus.in_op);
   assign a_ext = {is_signed_a(in_op) & bus.in_a[DATA_W-1], bus.in_a};
   assign b_ext = {is_signed_b(in_op) & bus.in_b[DATA_W-1], bus.in_b};

   // Low slices are unsigned, so they get a zero top bit to share the signed multiplier.
   assign a_lo = {1'b0, a_ext[H-1:0]};
   assign b_lo = {1'b0, b_ext[H-1:0]};
   assign a_hi = a_ext[DATA_W:H];
   assign b_hi = b_ext[DATA_W:H];

   nios_mul_pp #(.W(H + 1)) u_pp_ll (.a_i(a_lo), .b_i(b_lo), .p_o(ll_p));
   nios_mul_pp #(.W(H + 1)) u_pp_lh (.a_i(a_lo), .b_i(b_hi), .p_o(lh_p));
   nios_mul_pp #(.W(H + 1)) u_pp_hl (.a_i(a_hi), .b_i(b_lo), .p_o(hl_p));
   nios_mul_pp #(.W(H + 1)) u_pp_hh (.a_i(a_hi), .b_i(b_hi), .p_o(hh_p));

   // The sum wraps modulo 2^PW, which is exactly the full 2*DATA_W-bit product.
   always_comb begin
      prod     = sext(ll_q) + (sext(lh_q) << H) + (sext(hl_q) << H) + (sext(hh_q) << (2 * H));
      result_d = (op_q == OP_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
   end

   assign adv = ~s2_valid_q | bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         op_q       <= OP_MUL;
         tag1_q     <= '0;
         tag2_q     <= '0;
         ll_q       <= '0;
         lh_q       <= '0;
         hl_q       <= '0;
         hh_q       <= '0;
         result_q   <= '0;
      end else begin
         // Flush kills valids even while stalled; a coincident input is dropped.
         if (bus.flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
         end else if (adv) begin
            s1_valid_q <= bus.in_valid;
            s2_valid_q <= s1_valid_q;
         end
         if (adv) begin
            if (bus.in_valid) begin
               op_q   <= in_op;
               tag1_q <= bus.in_tag;
               ll_q   <= ll_p;
               lh_q   <= lh_p;
               hl_q   <= hl_p;
               hh_q   <= hh_p;
            end
            if (s1_valid_q) begin
               result_q <= result_d;
               tag2_q   <= tag1_q;
            end
         end
      end
   end

   assign bus.in_ready   = adv;
   assign bus.out_valid  = s2_valid_q;
   assign bus.out_result = result_q;
   assign bus.out_tag    = tag2_q;

endmodule

// File: tb/tb_nios_mul_pipe.sv
// Bench for nios_mul_pipe: directed vector table, backpressure/flush/reset sequences, and random
// traffic on a 32-bit and a 16-bit instance, all scored against a 64-bit reference model.
module tb_nios_mul_pipe;

   localparam int unsigned DW   = 32;
   localparam int unsigned DW16 = 16;
   localparam int unsigned TW   = 5;

   logic clk = 1'b0;
   logic reset_n;
   logic reset16_n;

   always #5 clk = ~clk;

   nios_mul_pipe_if #(.DATA_W(DW),   .TAG_W(TW)) bus   ();
   nios_mul_pipe_if #(.DATA_W(DW16), .TAG_W(TW)) bus16 ();

   nios_mul_pipe #(.DATA_W(DW),   .TAG_W(TW)) dut   (.clk(clk), .reset_n(reset_n),   .bus(bus));
   nios_mul_pipe #(.DATA_W(DW16), .TAG_W(TW)) dut16 (.clk(clk), .reset_n(reset16_n), .bus(bus16));

   typedef struct {
      logic [63:0]   res;
      logic [TW-1:0] tag;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;

   exp_t sb[$];
   exp_t sb16[$];
   int   errors = 0;
   int   checks = 0;
   int   n_out  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: extend operands to 64 bits per op, multiply mod 2^64, pick the word.
   function automatic logic [63:0] ref_mul(input int unsigned w, input logic [1:0] op,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask, ea, eb, p;
      mask = (64'd1 << w) - 64'd1;
      ea   = a & mask;
      eb   = b & mask;
      if ((op == 2'b01 || op == 2'b10) && a[w-1]) ea = ea | ~mask;
      if (op == 2'b01 && b[w-1]) eb = eb | ~mask;
      p = ea * eb;
      return (op == 2'b00) ? (p & mask) : ((p >> w) & mask);
   endfunction

   function automatic logic [63:0] pick(input int unsigned w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 4))
         0:       return 64'd0;
         1:       return mask;
         2:       return 64'd1 << (w - 1);
         3:       return mask >> 1;
         default: return {32'($urandom), 32'($urandom)} & mask;
      endcase
   endfunction

   // Scoreboard / monitor for the 32-bit instance, sampled between edges.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_res;
   logic [TW-1:0] prev_tag;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_result", 64'(bus.out_result), 64'(prev_res));
            check("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
         end
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got tag %0d result %h, expected no output",
                        bus.out_tag, bus.out_result);
            end else begin
               e = sb.pop_front();
               check("sb_result", 64'(bus.out_result), e.res);
               check("sb_tag", 64'(bus.out_tag), 64'(e.tag));
            end
         end
         if (bus.flush) begin
            sb.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            e.res = ref_mul(DW, bus.in_op, 64'(bus.in_a), 64'(bus.in_b));
            e.tag = bus.in_tag;
            sb.push_back(e);
         end
         prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
         prev_res   = bus.out_result;
         prev_tag   = bus.out_tag;
      end
   end

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (!reset16_n) begin
         sb16.delete();
      end else begin
         if (bus16.out_valid && bus16.out_ready) begin
            if (sb16.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb16_unexpected: got tag %0d result %h, expected no output",
                        bus16.out_tag, bus16.out_result);
            end else begin
               e = sb16.pop_front();
               check("sb16_result", 64'(bus16.out_result), e.res);
               check("sb16_tag", 64'(bus16.out_tag), 64'(e.tag));
            end
         end
         if (bus16.in_valid && bus16.in_ready) begin
            e.res = ref_mul(DW16, bus16.in_op, 64'(bus16.in_a), 64'(bus16.in_b));
            e.tag = bus16.in_tag;
            sb16.push_back(e);
         end
      end
   end

   initial begin
      vec_t vecs[10];
      int   c;
      int   sent;
      int   n0;
      logic acc;

      vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[4] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[5] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      vecs[7] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
      vecs[8] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};
      vecs[9] = '{2'b11, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001};

      reset_n         = 1'b0;
      reset16_n       = 1'b0;
      bus.flush       = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_op       = 2'b00;
      bus.in_a        = '0;
      bus.in_b        = '0;
      bus.in_tag      = '0;
      bus.out_ready   = 1'b0;
      bus16.flush     = 1'b0;
      bus16.in_valid  = 1'b0;
      bus16.in_op     = 2'b00;
      bus16.in_a      = '0;
      bus16.in_b      = '0;
      bus16.in_tag    = '0;
      bus16.out_ready = 1'b0;

      // Reset state
      tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_result", 64'(bus.out_result), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      reset_n         = 1'b1;
      reset16_n       = 1'b1;
      bus.out_ready   = 1'b1;
      bus16.out_ready = 1'b1;
      tick();

      // Directed vectors, one at a time, exact two-cycle latency
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_op    = vecs[i].op;
         bus.in_a     = vecs[i].a;
         bus.in_b     = vecs[i].b;
         bus.in_tag   = TW'(i);
         tick();
         bus.in_valid = 1'b0;
         check($sformatf("vec%0d_lat1_valid", i), 64'(bus.out_valid), 64'd0);
         tick();
         check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
         check($sformatf("vec%0d_result", i), 64'(bus.out_result), 64'(vecs[i].res));
         check($sformatf("vec%0d_tag", i), 64'(bus.out_tag), 64'(i));
      end
      tick();

      // Four back-to-back inputs, consumer stalls for three cycles
      n0   = n_out;
      c    = 0;
      sent = 0;
      while (sent < 4 && c < 40) begin
         bus.in_valid  = 1'b1;
         bus.in_op     = 2'(sent);
         bus.in_a      = 32'(100 + sent);
         bus.in_b      = 32'hFFFF_FFFD;
         bus.in_tag    = TW'(sent + 1);
         bus.out_ready = !(c >= 3 && c < 6);
         #1;
         if (c >= 3 && c < 6) check($sformatf("stall%0d_in_ready", c), 64'(bus.in_ready), 64'd0);
         acc = bus.in_ready;
         tick();
         if (acc) sent++;
         c++;
      end
      check("bp_all_sent", 64'(sent), 64'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
      check("bp_drained", 64'(sb.size()), 64'd0);
      check("bp_out_count", 64'(n_out - n0), 64'd4);

      // Flush with S1 and S2 full and a coincident input
      n0           = n_out;
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b00;
      bus.in_a     = 32'd1;
      bus.in_b     = 32'd10;
      bus.in_tag   = TW'(10);
      tick();
      bus.in_tag   = TW'(11);
      tick();
      bus.in_tag   = TW'(12);
      bus.flush    = 1'b1;
      #1;
      check("flush_s2_full", 64'(bus.out_valid), 64'd1);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.flush = 1'b0;
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      bus.in_a   = 32'd7;
      bus.in_b   = 32'd5;
      bus.in_tag = TW'(13);
      tick();
      bus.in_valid = 1'b0;
      check("post_flush_lat1", 64'(bus.out_valid), 64'd0);
      tick();
      check("post_flush_valid", 64'(bus.out_valid), 64'd1);
      check("post_flush_result", 64'(bus.out_result), 64'd35);
      check("post_flush_tag", 64'(bus.out_tag), 64'd13);
      tick();
      check("flush_out_count", 64'(n_out - n0), 64'd2);

      // Asynchronous reset mid-stream, between edges, with the output stalled
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd9;
      bus.in_b     = 32'd9;
      bus.in_tag   = TW'(20);
      tick();
      bus.in_tag   = TW'(21);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_out_result", 64'(bus.out_result), 64'd0);
      check("arst_out_tag", 64'(bus.out_tag), 64'd0);
      @(posedge clk);
      #3;
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_op     = 2'b00;
      bus.in_a      = 32'd2;
      bus.in_b      = 32'd3;
      bus.in_tag    = TW'(7);
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("arst_first_valid", 64'(bus.out_valid), 64'd1);
      check("arst_first_result", 64'(bus.out_result), 64'd6);
      check("arst_first_tag", 64'(bus.out_tag), 64'd7);
      tick();

      // Random traffic on both widths, with ready gaps and occasional flushes
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.in_valid    = ($urandom_range(0, 3) != 0);
         bus.in_op       = 2'($urandom_range(0, 3));
         bus.in_a        = 32'(pick(DW));
         bus.in_b        = 32'(pick(DW));
         bus.in_tag      = TW'($urandom);
         bus.out_ready   = ($urandom_range(0, 3) != 0);
         bus.flush       = ($urandom_range(0, 39) == 0);
         bus16.in_valid  = ($urandom_range(0, 3) != 0);
         bus16.in_op     = 2'($urandom_range(0, 3));
         bus16.in_a      = 16'(pick(DW16));
         bus16.in_b      = 16'(pick(DW16));
         bus16.in_tag    = TW'($urandom);
         bus16.out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      bus.in_valid    = 1'b0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      for (int k = 0; k < 30 && (sb.size() != 0 || sb16.size() != 0); k++) tick();
      check("rand_drain32", 64'(sb.size()), 64'd0);
      check("rand_drain16", 64'(sb16.size()), 64'd0);
      check("rand_idle32", 64'(bus.out_valid), 64'd0);
      check("rand_idle16", 64'(bus16.out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
